// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_BYTES = 4;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry registered output buffer presented to the IF/ID register.
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        load,
    input  logic        consume,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    // Next buffer contents: flush beats load beats consume; otherwise hold.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush) begin
            valid_d = 1'b0;
            inst_d  = NOP_WORD;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = load_pc;
            inst_d  = load_inst;
        end else if (consume) begin
            valid_d = 1'b0;
            inst_d  = NOP_WORD;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory, feeds IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        if_reg_clr
);

    import fetch_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic free;
    logic redirect;
    logic fire;
    logic consume;
    logic unused_target_lsbs;

    // Low target bits are dropped by word alignment.
    assign unused_target_lsbs = ^ex_target[1:0];

    // Handshake and buffer control; a redirect in BOOT is ignored.
    always_comb begin
        free     = ~if_valid | ~id_stall;
        redirect = ex_redirect & (state_q != BOOT);
        im_req   = (state_q == RUN) & free & ~ex_redirect;
        im_addr  = pc_q;
        fire     = im_req & im_ack;
        consume  = if_valid & ~id_stall & ~fire;
    end

    // Next state and next PC, redirect has highest priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            REDIR:   state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect) begin
            state_d = REDIR;
            pc_d    = align_word(ex_target);
        end else if (fire) begin
            pc_d = pc_q + 32'(INST_BYTES);
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_out_buf #(
        .RESET_PC (RESET_PC),
        .NOP_WORD (NOP_INST)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .load      (fire),
        .consume   (consume),
        .load_pc   (pc_q),
        .load_inst (im_rdata),
        .valid     (if_valid),
        .pc        (if_pc),
        .inst      (if_inst)
    );

    // IF/ID inserts a bubble whenever nothing real is buffered.
    assign if_reg_clr = ~if_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_reg_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_stall    (id_stall),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_ack      (im_ack),
        .im_rdata    (im_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .if_reg_clr  (if_reg_clr)
    );

    // Apply reset, check reset values, release; the next cycle is BOOT.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
        im_ack = 1'b0; im_rdata = 32'h0;
        #1;
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", im_req); end
        n_checks++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", im_addr); end
        n_checks++; if (if_reg_clr !== 1'b1) begin n_fail++; $display("FAIL rst_clr: got %b want 1", if_reg_clr); end
        n_checks++; if (if_inst !== NOP) begin n_fail++; $display("FAIL rst_inst: got %h want %h", if_inst, NOP); end
        n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", if_pc); end
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // BOOT bubble (redirect ignored there), then back-to-back fetch with ack tied high.
    task automatic test_back_to_back();
        do_reset();
        im_ack = 1'b1; ex_redirect = 1'b1; ex_target = 32'h40; #1;
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", im_req); end
        @(negedge clk);
        ex_redirect = 1'b0; ex_target = 32'h0;
        for (int i = 0; i < 3; i++) begin
            im_rdata = 32'hA000_0000 | 32'(i * 4); #1;
            n_checks++; if (im_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req%0d: got %b want 1", i, im_req); end
            n_checks++; if (im_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL b2b_addr%0d: got %h want %h", i, im_addr, 32'(i * 4)); end
            if (i > 0) begin
                n_checks++; if (if_inst !== (32'hA000_0000 | 32'((i - 1) * 4))) begin n_fail++; $display("FAIL b2b_inst%0d: got %h", i, if_inst); end
                n_checks++; if (if_reg_clr !== 1'b0) begin n_fail++; $display("FAIL b2b_clr%0d: got %b want 0", i, if_reg_clr); end
            end else begin
                n_checks++; if (if_reg_clr !== 1'b1) begin n_fail++; $display("FAIL b2b_clr0: got %b want 1", if_reg_clr); end
            end
            @(negedge clk);
        end
        im_ack = 1'b0; #1;
        n_checks++; if (if_inst !== 32'hA000_0008) begin n_fail++; $display("FAIL b2b_last_inst: got %h want a0000008", if_inst); end
        n_checks++; if (if_pc !== 32'h8) begin n_fail++; $display("FAIL b2b_last_pc: got %h want 8", if_pc); end
        n_checks++; if (im_addr !== 32'hC) begin n_fail++; $display("FAIL b2b_next_addr: got %h want c", im_addr); end
    endtask

    // Request waits on a missing ack with a stable address.
    task automatic test_ack_wait();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin n_fail++; $display("FAIL wait_req%0d: got req=%b addr=%h want 1/0", i, im_req, im_addr); end
            n_checks++; if (if_reg_clr !== 1'b1) begin n_fail++; $display("FAIL wait_clr%0d: got %b want 1", i, if_reg_clr); end
            @(negedge clk);
        end
        im_ack = 1'b1; im_rdata = 32'h1234_5678;
        @(negedge clk);
        im_ack = 1'b0; #1;
        n_checks++; if (if_inst !== 32'h1234_5678 || if_pc !== 32'h0) begin n_fail++; $display("FAIL wait_capture: got pc=%h inst=%h want 0/12345678", if_pc, if_inst); end
        n_checks++; if (im_addr !== 32'h4) begin n_fail++; $display("FAIL wait_pc_adv: got %h want 4", im_addr); end
        n_checks++; if (if_reg_clr !== 1'b0) begin n_fail++; $display("FAIL wait_clr_after: got %b want 0", if_reg_clr); end
    endtask

    // Stall holds the buffer and blocks requests.
    task automatic test_stall();
        do_reset();
        @(negedge clk);
        im_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            im_rdata = 32'hD000_0000 | 32'(i * 4);
            @(negedge clk);
        end
        id_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            im_rdata = 32'hBAD0_0000; #1;
            n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %b want 0", i, im_req); end
            n_checks++; if (if_pc !== 32'h8 || if_inst !== 32'hD000_0008) begin n_fail++; $display("FAIL stall_hold%0d: got pc=%h inst=%h want 8/d0000008", i, if_pc, if_inst); end
            @(negedge clk);
        end
        id_stall = 1'b0; #1;
        n_checks++; if (im_req !== 1'b1 || im_addr !== 32'hC) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h want 1/c", im_req, im_addr); end
    endtask

    // Redirect discards an acked word, bubbles once, then fetches the aligned target.
    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        im_ack = 1'b1; im_rdata = 32'hD000_0000;
        @(negedge clk);
        ex_redirect = 1'b1; ex_target = 32'h103; im_rdata = 32'hBAD0_0000; #1;
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b want 0", im_req); end
        @(negedge clk);
        ex_redirect = 1'b0; ex_target = 32'h0; #1;
        n_checks++; if (if_valid !== 1'b0 || if_inst !== NOP || if_reg_clr !== 1'b1) begin n_fail++; $display("FAIL redir_flush: got v=%b inst=%h clr=%b want 0/%h/1", if_valid, if_inst, if_reg_clr, NOP); end
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL redir_bubble: got %b want 0", im_req); end
        @(negedge clk);
        im_rdata = 32'hCAFE_0100; #1;
        n_checks++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin n_fail++; $display("FAIL redir_target: got req=%b addr=%h want 1/100", im_req, im_addr); end
        @(negedge clk);
        im_ack = 1'b0; #1;
        n_checks++; if (if_pc !== 32'h100 || if_inst !== 32'hCAFE_0100) begin n_fail++; $display("FAIL redir_capture: got pc=%h inst=%h want 100/cafe0100", if_pc, if_inst); end
    endtask

    // Redirect during a stall flushes the held instruction.
    task automatic test_redirect_stall();
        do_reset();
        @(negedge clk);
        im_ack = 1'b1; im_rdata = 32'hD000_0000;
        @(negedge clk);
        id_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h200; #1;
        n_checks++; if (im_req !== 1'b0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL rs_pre: got req=%b v=%b want 0/1", im_req, if_valid); end
        @(negedge clk);
        id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0; #1;
        n_checks++; if (if_inst !== NOP || if_reg_clr !== 1'b1) begin n_fail++; $display("FAIL rs_flush: got inst=%h clr=%b want %h/1", if_inst, if_reg_clr, NOP); end
        n_checks++; if (im_req !== 1'b0) begin n_fail++; $display("FAIL rs_bubble: got %b want 0", im_req); end
        @(negedge clk); #1;
        n_checks++; if (im_req !== 1'b1 || im_addr !== 32'h200) begin n_fail++; $display("FAIL rs_resume: got req=%b addr=%h want 1/200", im_req, im_addr); end
    endtask

    // PC wraps from the top word to zero.
    task automatic test_pc_wrap();
        do_reset();
        @(negedge clk);
        ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFF;
        @(negedge clk);
        ex_redirect = 1'b0; ex_target = 32'h0;
        @(negedge clk);
        im_ack = 1'b1; im_rdata = 32'h7777_7777; #1;
        n_checks++; if (im_req !== 1'b1 || im_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffc", im_req, im_addr); end
        @(negedge clk);
        im_ack = 1'b0; #1;
        n_checks++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", im_addr); end
        n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_inst !== 32'h7777_7777) begin n_fail++; $display("FAIL wrap_capture: got pc=%h inst=%h", if_pc, if_inst); end
    endtask

    initial begin
        rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = 32'h0;
        im_ack = 1'b0; im_rdata = 32'h0;
        test_back_to_back();
        test_ack_wait();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the architectural PC and issues requests to instruction memory over a req/ack handshake.
- Holds one fetched instruction in a registered output buffer and presents it to IF/ID as if_pc/if_inst, with if_reg_clr asserted whenever no valid instruction is available.
- Handles decode-stage stalls and EX-stage control-flow redirects (branch/jump).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- NOP_INST, 32'h0000_0013, encoding driven on if_inst when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- id_stall  input  1  decode/hazard stall; buffer must hold its contents.
- ex_redirect  input  1  taken branch/jump from EX.
- ex_target  input  32  redirect target PC.
- im_req  output  1  instruction-memory request.
- im_addr  output  32  request address, word aligned.
- im_ack  input  1  memory accepts the request; im_rdata is valid in the same cycle.
- im_rdata  input  32  fetched instruction word.
- if_pc  output  32  PC of the buffered instruction.
- if_inst  output  32  buffered instruction, or NOP_INST when empty.
- if_valid  output  1  buffer holds a real instruction.
- if_reg_clr  output  1  equals ~if_valid; IF/ID inserts a NOP.

Behaviour:
- Reset (asynchronous):
  - pc_q=RESET_PC, state=BOOT, if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC.
  - Combinational outputs during reset: im_req=0, im_addr=RESET_PC, if_reg_clr=1.
- FSM states: BOOT, RUN, REDIR.
  - BOOT: im_req=0; go to RUN next cycle.
  - RUN: normal fetch.
  - REDIR: single bubble cycle after a redirect, im_req=0; go to RUN next cycle.
- Buffer free condition: free = ~if_valid | ~id_stall.
- Request signals (combinational):
  - im_req = (state==RUN) & free & ~ex_redirect.
  - im_addr = pc_q.
  - im_req may drop without ack. A transfer exists only in a cycle where fire = im_req & im_ack.
- Update priority per cycle, highest first:
  1. ex_redirect (any state except BOOT; in BOOT it is ignored):
     - pc_q <= {ex_target[31:2],2'b00}.
     - if_valid <= 0, if_inst <= NOP_INST.
     - state <= REDIR.
     - Any im_ack in this cycle is ignored, because im_req=0.
  2. fire:
     - if_inst <= im_rdata, if_pc <= pc_q, if_valid <= 1.
     - pc_q <= pc_q + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  3. if_valid & ~id_stall and no fire: buffer consumed, so if_valid <= 0 and if_inst <= NOP_INST.
  4. Otherwise: hold all state.
- Stall:
  - With if_valid=1 and id_stall=1, im_req=0 and if_pc/if_inst are held stable for any number of cycles.
- Throughput and latency:
  - Back-to-back fire with no stall gives one instruction per cycle.
  - Fetch-to-output latency is 1 cycle: the rdata accepted at edge N is visible on if_inst after edge N.
- Redirect latency:
  - Redirect asserted in cycle N.
  - Cycle N+1 is the REDIR bubble.
  - The first request to the target is issued in cycle N+2.
  - Its instruction appears after edge N+2 if acked.
- Simultaneous events:
  - redirect + id_stall: redirect wins and the buffer is flushed.
  - fire + consume: the new word replaces the old one and if_valid stays 1.
- if_reg_clr is purely combinational from if_valid, with no extra flop.

Decomposition:
- Shared package fetch_pkg:
  - typedef enum logic [1:0] {BOOT, RUN, REDIR} fetch_state_t.
  - localparam NOP_INST = 32'h0000_0013.
  - localparam INST_BYTES = 4.
- One sub-module, fetch_out_buf: the one-entry output buffer (if_valid/if_pc/if_inst with load/clear/hold).
- The FSM and PC logic stay in if_fetch_unit.

Test Plan:
- Reset then im_ack tied 1 -> BOOT bubble, then im_addr 0x0, 0x4, 0x8 on consecutive cycles; if_inst follows im_rdata one cycle later; if_reg_clr=0 from the first fetch onward.
- im_ack held 0 for 3 cycles, then 1 -> im_req stays 1 with im_addr constant 0x0; if_reg_clr=1 throughout the wait; one instruction is captured at 0x0 and pc_q advances to 0x4.
- Buffer valid (pc 0x8) with id_stall=1 for 4 cycles -> im_req=0; if_pc=0x8 and if_inst are held; after release, the next fetch is 0xC.
- ex_redirect with ex_target=0x103 while im_ack=1 -> acked word discarded; if_valid=0 next cycle; one REDIR bubble; then im_addr=0x100.
- ex_redirect together with id_stall=1 and a valid buffer -> buffer flushed to NOP_INST, if_reg_clr=1; fetch resumes at the target two cycles later.
- pc_q=0xFFFF_FFFC fetched -> next im_addr=0x0000_0000.
